mem_stage_ahb: RTL and testbench
================================

Name: mem_stage_ahb

Overview:
- Parametrised memory-access pipeline stage between execute and write-back.
- Issues loads and stores of byte, half, word and double size as AHB-Lite transfers, with separate address and data phases and HREADY wait states.
- Performs byte-lane placement for stores, and lane extraction plus sign/zero extension for loads.
- Flags misaligned accesses and bus errors; stalls upstream via ready_o while a transfer is in flight.

Parameters:
- XLEN, 64, data and bus width; legal values 32 or 64.
- ADDR_W, 64, HADDR width.
- LANE_BITS, $clog2(XLEN/8), address bits selecting the byte lane.

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- RST  in  1  synchronous, active-high reset.
- valid_i  in  1  upstream instruction valid.
- ready_o  out  1  stage can accept; combinational, equals (state==IDLE).
- is_load_i  in  1  instruction is a load.
- is_store_i  in  1  instruction is a store.
- funct3_i  in  3  bits [1:0] are size (0=B, 1=H, 2=W, 3=D); bit 2 means unsigned load.
- addr_i  in  ADDR_W  effective address.
- store_data_i  in  XLEN  store value, LSB-aligned.
- alu_res_i  in  XLEN  pass-through result for non-memory instructions.
- rd_i  in  5  destination register.
- wb_en_i  in  1  instruction writes rd.
- HADDR  out  ADDR_W  AHB address.
- HTRANS  out  2  AHB transfer type; 2'b00 IDLE, 2'b10 NONSEQ.
- HWRITE  out  1  AHB write.
- HSIZE  out  3  AHB size, equal to funct3 size.
- HWDATA  out  XLEN  AHB write data.
- HRDATA  in  XLEN  AHB read data.
- HREADY  in  1  transfer phase complete.
- HRESP  in  1  AHB error response.
- valid_o  out  1  one-cycle result strobe.
- res_o  out  XLEN  load data or ALU result.
- rd_o  out  5  destination register.
- wb_en_o  out  1  write-back enable; forced 0 on any exception.
- misalign_o  out  1  misaligned or illegal-size access, valid with valid_o.
- bus_err_o  out  1  HRESP error, valid with valid_o.

Behaviour:
- Reset values, applied on the CLK edge with RST=1:
  - state=IDLE, HTRANS=IDLE, HWRITE=0, HADDR=0, HSIZE=0, HWDATA=0.
  - valid_o=0, res_o=0, rd_o=0, wb_en_o=0, misalign_o=0, bus_err_o=0.
- Reset mid-transfer: the in-flight access is abandoned and no valid_o is produced. HTRANS=IDLE from the next cycle.
- States: IDLE, ADDR, DATA. All outputs except ready_o are registered.
- Acceptance: the edge where valid_i & ready_o.
- Access classification:
  - mem = is_load_i | is_store_i.
  - Misaligned when addr_i[size-1:0] != 0.
  - Illegal when size==3 and XLEN==32; treated the same as misaligned.
- IDLE, non-memory instruction accepted:
  - Next cycle: valid_o=1, res_o=alu_res_i, rd_o=rd_i, wb_en_o=wb_en_i.
  - Latency 1. Stays in IDLE, so throughput is 1 per cycle.
- IDLE, misaligned memory instruction accepted:
  - No bus transfer.
  - Next cycle: valid_o=1, misalign_o=1, wb_en_o=0, res_o=0.
- IDLE, aligned memory instruction accepted:
  - Registers HADDR=addr_i, HWRITE=is_store_i, HSIZE=size, HTRANS=NONSEQ.
  - Latches rd, wb_en, funct3 and addr[LANE_BITS-1:0].
  - Stores: HWDATA = store_data_i shifted left by 8*lane. The value is latched here and held through DATA.
  - Goes to ADDR.
- ADDR:
  - If HREADY=1: HTRANS<=IDLE, go to DATA.
  - Else hold all address-phase signals.
- DATA:
  - If HREADY=1: go to IDLE and set valid_o=1.
  - Loads: res_o = extend(HRDATA >> 8*lane, size, unsigned); wb_en_o = latched wb_en.
  - Stores: res_o=0, wb_en_o=0.
  - If HRESP=1 with HREADY=1: bus_err_o=1, wb_en_o=0.
  - HREADY=0: wait; a wait state with HRESP=1 is ignored.
- Zero-wait-state memory latency: accepted at edge N, valid_o is high in the cycle after edge N+2. Each HREADY=0 cycle adds 1.
- Extension: B/H/W sign-extend from bit 7/15/31 when unsigned=0, zero-extend otherwise. D passes through unchanged.
- valid_o, misalign_o and bus_err_o are single-cycle pulses, cleared on every edge that does not set them.
- ready_o=0 in ADDR and DATA. Upstream holds its inputs stable while stalled.

Decomposition:
- Shared package mem_pkg:
  - funct3 size codes (SZ_B, SZ_H, SZ_W, SZ_D) and the unsigned-bit index.
  - HTRANS encodings (HTRANS_IDLE, HTRANS_NONSEQ).
  - State encoding (ST_IDLE, ST_ADDR, ST_DATA).
- One combinational sub-module, mem_load_align: lane shift plus sign/zero extension, parametrised by XLEN. It is reused by the future cache refill path.

Test Plan:
- Non-mem: valid_i=1, alu_res_i=64'h1234, rd_i=5, wb_en_i=1 -> next cycle valid_o=1, res_o=64'h1234, rd_o=5, wb_en_o=1, HTRANS stays 0.
- LB signed: addr_i=64'h1003, HRDATA=64'h00000000_80000000 with byte 3 = 8'h80, HREADY=1 -> HTRANS=2 for one cycle, valid_o 3 cycles after acceptance, res_o=64'hFFFF_FFFF_FFFF_FF80. Repeated with funct3=LBU -> res_o=64'h80.
- SH: addr_i=64'h2006, store_data_i=64'hBEEF -> HWDATA=64'hBEEF_0000_0000_0000, HSIZE=1, HWRITE=1, wb_en_o=0 on valid_o.
- Wait states: LD with HREADY=0 for 2 cycles in DATA -> ready_o low 4 cycles total, valid_o at acceptance+5, res_o=HRDATA.
- Misalign: LW at addr_i=64'h1002 -> no HTRANS activity, next cycle valid_o=1, misalign_o=1, wb_en_o=0. With XLEN=32, LD at any address -> misalign_o=1.
- Error and reset: HRESP=1 with HREADY=1 in DATA -> bus_err_o=1, wb_en_o=0. RST=1 asserted in ADDR -> next cycle HTRANS=0, ready_o=1, no valid_o pulse.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: funct3 size codes, AHB transfer types,
// FSM state constants and the alignment check.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam int         F3_UNS_BIT = 2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = |lo[1:0];
      default: bad = |lo;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane extraction: shifts the addressed bytes down to bit 0, then
// sign- or zero-extends according to funct3. Shared with the cache refill path.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int LANE_BITS = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]      data,
  input  logic [LANE_BITS-1:0] lane,
  input  logic [2:0]           funct3,
  output logic [XLEN-1:0]      result
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign;
  logic            uns;

  // Masking instead of replication keeps the word case legal when XLEN is 32.
  always_comb begin
    shifted = data >> {lane, 3'b000};
    uns     = funct3[F3_UNS_BIT];
    mask    = '1;
    sign    = 1'b0;
    case (funct3[1:0])
      SZ_B: begin
        mask = XLEN'(8'hFF);
        sign = shifted[7];
      end
      SZ_H: begin
        mask = XLEN'(16'hFFFF);
        sign = shifted[15];
      end
      SZ_W: begin
        mask = XLEN'(32'hFFFF_FFFF);
        sign = shifted[31];
      end
      default: begin
        mask = '1;
        sign = 1'b0;
      end
    endcase
    result = (shifted & mask) | ((sign & ~uns) ? ~mask : '0);
  end

endmodule

// File: rtl/mem_stage_ahb.sv
// Memory-access pipeline stage: issues loads/stores as single AHB-Lite transfers
// and hands results, misalignment and bus errors on to write-back.
module mem_stage_ahb
  import mem_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int ADDR_W    = 64,
  parameter int LANE_BITS = $clog2(XLEN / 8)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [XLEN-1:0]   alu_res_i,
  input  logic [4:0]        rd_i,
  input  logic              wb_en_i,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [XLEN-1:0]   HWDATA,
  input  logic [XLEN-1:0]   HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              valid_o,
  output logic [XLEN-1:0]   res_o,
  output logic [4:0]        rd_o,
  output logic              wb_en_o,
  output logic              misalign_o,
  output logic              bus_err_o
);

  logic [1:0]           state;
  logic [LANE_BITS-1:0] lane_q;
  logic [2:0]           funct3_q;
  logic [4:0]           rd_q;
  logic                 wb_en_q;

  logic                 accept;
  logic                 mem;
  logic                 bad_access;
  logic [1:0]           size_in;
  logic [XLEN-1:0]      store_shifted;
  logic [XLEN-1:0]      load_val;

  assign ready_o       = (state == ST_IDLE);
  assign accept        = valid_i & ready_o;
  assign mem           = is_load_i | is_store_i;
  assign size_in       = funct3_i[1:0];
  // Doubleword accesses cannot be carried on a 32-bit bus, so they trap like misalignment.
  assign bad_access    = misaligned(size_in, addr_i[2:0]) | ((size_in == SZ_D) && (XLEN == 32));
  assign store_shifted = store_data_i << {addr_i[LANE_BITS-1:0], 3'b000};

  mem_load_align #(.XLEN(XLEN)) u_load_align (
    .data   (HRDATA),
    .lane   (lane_q),
    .funct3 (funct3_q),
    .result (load_val)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      HTRANS     <= HTRANS_IDLE;
      HWRITE     <= 1'b0;
      HADDR      <= '0;
      HSIZE      <= '0;
      HWDATA     <= '0;
      valid_o    <= 1'b0;
      res_o      <= '0;
      rd_o       <= '0;
      wb_en_o    <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      lane_q     <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      wb_en_q    <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!mem) begin
              valid_o <= 1'b1;
              res_o   <= alu_res_i;
              rd_o    <= rd_i;
              wb_en_o <= wb_en_i;
            end else if (bad_access) begin
              valid_o    <= 1'b1;
              misalign_o <= 1'b1;
              res_o      <= '0;
              rd_o       <= rd_i;
              wb_en_o    <= 1'b0;
            end else begin
              HADDR    <= addr_i;
              HWRITE   <= is_store_i;
              HSIZE    <= {1'b0, size_in};
              HTRANS   <= HTRANS_NONSEQ;
              lane_q   <= addr_i[LANE_BITS-1:0];
              funct3_q <= funct3_i;
              rd_q     <= rd_i;
              wb_en_q  <= wb_en_i;
              if (is_store_i) HWDATA <= store_shifted;
              state    <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            HTRANS <= HTRANS_IDLE;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          // Error responses during wait states are ignored; only the final phase counts.
          if (HREADY) begin
            state   <= ST_IDLE;
            valid_o <= 1'b1;
            rd_o    <= rd_q;
            if (HWRITE) begin
              res_o   <= '0;
              wb_en_o <= 1'b0;
            end else begin
              res_o   <= load_val;
              wb_en_o <= wb_en_q & ~HRESP;
            end
            bus_err_o <= HRESP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ahb.sv
// Directed bench for mem_stage_ahb: table of single transactions plus hand-built
// wait-state, bus-error, reset and 32-bit sequences.
module tb_mem_stage_ahb;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        is_load_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [63:0] addr_i = '0;
  logic [63:0] store_data_i = '0;
  logic [63:0] alu_res_i = '0;
  logic [4:0]  rd_i = '0;
  logic        wb_en_i = 1'b0;
  logic [63:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic        valid_o;
  logic [63:0] res_o;
  logic [4:0]  rd_o;
  logic        wb_en_o;
  logic        misalign_o;
  logic        bus_err_o;

  logic        valid32 = 1'b0;
  logic        ready32;
  logic [31:0] haddr32, hwdata32, res32;
  logic [1:0]  htrans32;
  logic        hwrite32, valid_o32, wb_en32, misalign32, bus_err32;
  logic [2:0]  hsize32;
  logic [4:0]  rd32;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mem_stage_ahb dut (
    .CLK(CLK), .RST(RST), .valid_i(valid_i), .ready_o(ready_o),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .store_data_i(store_data_i), .alu_res_i(alu_res_i),
    .rd_i(rd_i), .wb_en_i(wb_en_i), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .valid_o(valid_o), .res_o(res_o),
    .rd_o(rd_o), .wb_en_o(wb_en_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  mem_stage_ahb #(.XLEN(32), .ADDR_W(32)) dut32 (
    .CLK(CLK), .RST(RST), .valid_i(valid32), .ready_o(ready32),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .funct3_i(funct3_i),
    .addr_i(addr_i[31:0]), .store_data_i(store_data_i[31:0]), .alu_res_i(alu_res_i[31:0]),
    .rd_i(rd_i), .wb_en_i(wb_en_i), .HADDR(haddr32), .HTRANS(htrans32),
    .HWRITE(hwrite32), .HSIZE(hsize32), .HWDATA(hwdata32), .HRDATA(32'h0),
    .HREADY(1'b1), .HRESP(1'b0), .valid_o(valid_o32), .res_o(res32),
    .rd_o(rd32), .wb_en_o(wb_en32), .misalign_o(misalign32), .bus_err_o(bus_err32)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] sdata;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic        wb;
    logic [63:0] hrdata;
    logic        xfer;
    logic [63:0] exp_hwdata;
    logic [63:0] exp_res;
    logic        exp_wb;
    logic        exp_mis;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    is_load_i    = v.ld;
    is_store_i   = v.st;
    funct3_i     = v.f3;
    addr_i       = v.addr;
    store_data_i = v.sdata;
    alu_res_i    = v.alu;
    rd_i         = v.rd;
    wb_en_i      = v.wb;
    HRDATA       = v.hrdata;
    valid_i      = 1'b1;
  endtask

  task automatic run_vector(input int i, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", i);
    apply_stimulus(v);
    step();
    valid_i = 1'b0;
    if (v.xfer) begin
      check_output({tag, ".htrans_nonseq"}, 64'(HTRANS), 64'(2'b10));
      check_output({tag, ".ready_low"}, 64'(ready_o), 64'd0);
      check_output({tag, ".haddr"}, HADDR, v.addr);
      check_output({tag, ".hwrite"}, 64'(HWRITE), 64'(v.st));
      check_output({tag, ".hsize"}, 64'(HSIZE), {62'd0, v.f3[1:0]});
      if (v.st) check_output({tag, ".hwdata"}, HWDATA, v.exp_hwdata);
      step();
      check_output({tag, ".htrans_idle"}, 64'(HTRANS), 64'd0);
      check_output({tag, ".no_early_valid"}, 64'(valid_o), 64'd0);
      step();
    end
    check_output({tag, ".valid"}, 64'(valid_o), 64'd1);
    check_output({tag, ".res"}, res_o, v.exp_res);
    check_output({tag, ".rd"}, 64'(rd_o), 64'(v.rd));
    check_output({tag, ".wb_en"}, 64'(wb_en_o), 64'(v.exp_wb));
    check_output({tag, ".misalign"}, 64'(misalign_o), 64'(v.exp_mis));
    check_output({tag, ".bus_err"}, 64'(bus_err_o), 64'd0);
    check_output({tag, ".ready_back"}, 64'(ready_o), 64'd1);
    if (!v.xfer) check_output({tag, ".no_htrans"}, 64'(HTRANS), 64'd0);
    step();
    check_output({tag, ".valid_pulse"}, 64'(valid_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    //          ld    st    f3      addr          sdata        alu          rd     wb    hrdata                   xfer  hwdata                  res                      wb    mis
    vecs[0]  = '{1'b0, 1'b0, 3'b000, 64'h0,      64'h0,      64'h1234,    5'd5,  1'b1, 64'h0,                   1'b0, 64'h0,                  64'h1234,                1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 64'h1003,   64'h0,      64'h0,       5'd7,  1'b1, 64'h0000_0000_8000_0000, 1'b1, 64'h0,                  64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 64'h1003,   64'h0,      64'h0,       5'd8,  1'b1, 64'h0000_0000_8000_0000, 1'b1, 64'h0,                  64'h80,                  1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 64'h2006,   64'hBEEF,   64'h0,       5'd9,  1'b1, 64'h0,                   1'b1, 64'hBEEF_0000_0000_0000, 64'h0,                  1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 64'h1002,   64'h0,      64'h0,       5'd10, 1'b1, 64'h0,                   1'b0, 64'h0,                  64'h0,                   1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 64'h10,     64'h0,      64'h0,       5'd11, 1'b1, 64'h0000_0000_0000_8001, 1'b1, 64'h0,                  64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b010, 64'h4,      64'h0,      64'h0,       5'd12, 1'b1, 64'h8765_4321_0000_0000, 1'b1, 64'h0,                  64'hFFFF_FFFF_8765_4321, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'b110, 64'h4,      64'h0,      64'h0,       5'd13, 1'b1, 64'h8765_4321_0000_0000, 1'b1, 64'h0,                  64'h0000_0000_8765_4321, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'b011, 64'h8,      64'h0,      64'h0,       5'd14, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0,                  64'h0123_4567_89AB_CDEF, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3'b101, 64'h6,      64'h0,      64'h0,       5'd15, 1'b0, 64'hFEDC_0000_0000_0000, 1'b1, 64'h0,                  64'hFEDC,                1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'b000, 64'h3001,   64'hAB,     64'h0,       5'd16, 1'b0, 64'h0,                   1'b1, 64'h0000_0000_0000_AB00, 64'h0,                  1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 3'b011, 64'h4,      64'h55,     64'h0,       5'd17, 1'b0, 64'h0,                   1'b0, 64'h0,                  64'h0,                   1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 3'b000, 64'h0,      64'h0,      64'hDEAD,    5'd31, 1'b0, 64'h0,                   1'b0, 64'h0,                  64'hDEAD,                1'b0, 1'b0};

    // Reset state
    RST = 1'b1;
    step();
    step();
    check_output("rst.htrans", 64'(HTRANS), 64'd0);
    check_output("rst.haddr", HADDR, 64'd0);
    check_output("rst.hwrite", 64'(HWRITE), 64'd0);
    check_output("rst.hsize", 64'(HSIZE), 64'd0);
    check_output("rst.hwdata", HWDATA, 64'd0);
    check_output("rst.valid", 64'(valid_o), 64'd0);
    check_output("rst.res", res_o, 64'd0);
    check_output("rst.rd", 64'(rd_o), 64'd0);
    check_output("rst.wb_en", 64'(wb_en_o), 64'd0);
    check_output("rst.misalign", 64'(misalign_o), 64'd0);
    check_output("rst.bus_err", 64'(bus_err_o), 64'd0);
    check_output("rst.ready", 64'(ready_o), 64'd1);
    RST = 1'b0;
    step();

    for (int i = 0; i < NVEC; i++) run_vector(i, vecs[i]);

    // Doubleword load with two DATA-phase wait states; an error flag during a wait is ignored
    is_load_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b011; addr_i = 64'h40;
    rd_i = 5'd3; wb_en_i = 1'b1; HRDATA = 64'h1122_3344_5566_7788; HREADY = 1'b1;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    check_output("ws.ready_c1", 64'(ready_o), 64'd0);
    step();
    check_output("ws.ready_c2", 64'(ready_o), 64'd0);
    HREADY = 1'b0; HRESP = 1'b1;
    step();
    check_output("ws.ready_c3", 64'(ready_o), 64'd0);
    check_output("ws.valid_c3", 64'(valid_o), 64'd0);
    HRESP = 1'b0;
    step();
    check_output("ws.ready_c4", 64'(ready_o), 64'd0);
    check_output("ws.valid_c4", 64'(valid_o), 64'd0);
    HREADY = 1'b1;
    step();
    check_output("ws.valid", 64'(valid_o), 64'd1);
    check_output("ws.res", res_o, 64'h1122_3344_5566_7788);
    check_output("ws.wb_en", 64'(wb_en_o), 64'd1);
    check_output("ws.bus_err", 64'(bus_err_o), 64'd0);
    check_output("ws.ready", 64'(ready_o), 64'd1);

    // Error response on the completing data phase
    funct3_i = 3'b010; addr_i = 64'h80; rd_i = 5'd4; wb_en_i = 1'b1;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    HRESP = 1'b1;
    step();
    HRESP = 1'b0;
    check_output("err.valid", 64'(valid_o), 64'd1);
    check_output("err.bus_err", 64'(bus_err_o), 64'd1);
    check_output("err.wb_en", 64'(wb_en_o), 64'd0);
    step();
    check_output("err.bus_err_pulse", 64'(bus_err_o), 64'd0);

    // Reset while stuck in the address phase
    funct3_i = 3'b011; addr_i = 64'h100; rd_i = 5'd6; wb_en_i = 1'b1;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    HREADY = 1'b0;
    step();
    check_output("rstmid.htrans_held", 64'(HTRANS), 64'(2'b10));
    check_output("rstmid.haddr_held", HADDR, 64'h100);
    RST = 1'b1;
    step();
    RST = 1'b0;
    HREADY = 1'b1;
    check_output("rstmid.htrans", 64'(HTRANS), 64'd0);
    check_output("rstmid.ready", 64'(ready_o), 64'd1);
    check_output("rstmid.valid", 64'(valid_o), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check_output($sformatf("rstmid.no_valid%0d", c), 64'(valid_o), 64'd0);
    end

    // 32-bit instance: any doubleword access is illegal
    is_load_i = 1'b1; funct3_i = 3'b011; addr_i = 64'h0; rd_i = 5'd2; wb_en_i = 1'b1;
    valid32 = 1'b1;
    step();
    valid32 = 1'b0;
    check_output("x32.valid", 64'(valid_o32), 64'd1);
    check_output("x32.misalign", 64'(misalign32), 64'd1);
    check_output("x32.wb_en", 64'(wb_en32), 64'd0);
    check_output("x32.htrans", 64'(htrans32), 64'd0);

    // 32-bit instance: aligned signed halfword from lane 2
    funct3_i = 3'b001; addr_i = 64'h6;
    valid32 = 1'b1;
    step();
    valid32 = 1'b0;
    check_output("x32.h_htrans", 64'(htrans32), 64'(2'b10));
    check_output("x32.h_haddr", 64'(haddr32), 64'h6);
    is_load_i = 1'b0;
    step();
    step();
    check_output("x32.h_valid", 64'(valid_o32), 64'd1);
    check_output("x32.h_res", 64'(res32), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
